// File: rtl/simd_pkg.sv
// Shared lane geometry and packer state encoding for the SIMD vector ALU front end.
package simd_pkg;
  localparam int LANE_W = 16;
  localparam int LANES  = 16;
  localparam int VEC_W  = LANE_W * LANES;
  localparam int CNT_W  = 5;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    PRIMED  = 2'd2
  } pk_state_t;
endpackage

// File: rtl/vec_out_slot.sv
// Single-entry valid/ready output register for assembled vectors.
module vec_out_slot
  import simd_pkg::*;
#(
  parameter int VEC_W = simd_pkg::VEC_W,
  parameter int CW    = simd_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [VEC_W-1:0] i_vec,
  input  logic [CW-1:0]    i_count,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [VEC_W-1:0] o_vec,
  output logic [CW-1:0]    o_count
);

  // A load may coincide with the retirement of the previous vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_vec   <= '0;
      o_count <= '0;
    end else if (i_load) begin
      o_valid <= 1'b1;
      o_vec   <= i_vec;
      o_count <= i_count;
    end else if (o_valid && i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/vec_sample_packer.sv
// Packs 16-bit samples into 16-lane vectors (lane 0 = newest) for the SIMD ALU.
// Define SLIDE_WINDOW_EN to enable sliding-window emission via slide_mode.
module vec_sample_packer
  import simd_pkg::*;
#(
  parameter int LANE_W = simd_pkg::LANE_W,
  parameter int LANES  = simd_pkg::LANES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       slide_mode,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANE_W-1:0]          in_data,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANE_W*LANES-1:0]    out_vec,
  output logic [$clog2(LANES):0]     out_count
);

  localparam int VEC_W  = LANE_W * LANES;
  localparam int HIST_W = VEC_W - LANE_W;
  localparam int CW     = $clog2(LANES) + 1;

  // Only the 15 older lanes are stored; lane 0 always comes straight from in_data.
  pk_state_t          r_state;
  logic [HIST_W-1:0]  r_hist;
  logic [CW-1:0]      r_cnt;

  logic [VEC_W-1:0]   w_shift;
  logic [CW-1:0]      w_count;
  logic               w_primed, w_keep, w_cand, w_accept, w_complete;

  assign w_shift = {r_hist, in_data};

`ifdef SLIDE_WINDOW_EN
  logic r_slide;
  logic w_slide;
  // Mode is sampled only while empty so a window is never reinterpreted mid-fill.
  assign w_slide  = (r_state == EMPTY) ? slide_mode : r_slide;
  assign w_primed = (r_state == PRIMED);
  assign w_keep   = w_slide & ~in_last;
`else
  logic w_unused_slide;
  assign w_unused_slide = slide_mode;
  assign w_primed = 1'b0;
  assign w_keep   = 1'b0;
`endif

  assign w_cand     = (r_cnt == CW'(LANES - 1)) | in_last | w_primed;
  assign in_ready   = ~rst & ~flush & (~w_cand | ~out_valid | out_ready);
  assign w_accept   = in_valid & in_ready;
  assign w_complete = w_accept & w_cand;
  assign w_count    = w_primed ? CW'(LANES) : r_cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EMPTY;
      r_hist  <= '0;
      r_cnt   <= '0;
`ifdef SLIDE_WINDOW_EN
      r_slide <= 1'b0;
`endif
    end else begin
`ifdef SLIDE_WINDOW_EN
      r_slide <= w_slide;
`endif
      if (flush) begin
        r_state <= EMPTY;
        r_hist  <= '0;
        r_cnt   <= '0;
      end else if (w_accept) begin
        if (w_complete && !w_keep) begin
          r_state <= EMPTY;
          r_hist  <= '0;
          r_cnt   <= '0;
        end else begin
          r_hist  <= w_shift[HIST_W-1:0];
          r_cnt   <= w_complete ? CW'(LANES) : r_cnt + 1'b1;
          r_state <= w_complete ? PRIMED : FILLING;
        end
      end
    end
  end

  vec_out_slot #(.VEC_W(VEC_W), .CW(CW)) u_slot (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_complete),
    .i_vec   (w_shift),
    .i_count (w_count),
    .i_ready (out_ready),
    .o_valid (out_valid),
    .o_vec   (out_vec),
    .o_count (out_count)
  );

endmodule

// File: tb/tb_vec_sample_packer.sv
// Randomized self-checking bench for vec_sample_packer with a queue-based window model.
module tb_vec_sample_packer;

`ifdef SLIDE_WINDOW_EN
  localparam bit SLIDE_EN = 1'b1;
`else
  localparam bit SLIDE_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, flush, slide_mode, in_valid, in_ready, in_last, out_valid, out_ready;
  logic [15:0]  in_data;
  logic [255:0] out_vec;
  logic [4:0]   out_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0]  m_win[$];
  bit           m_slide, m_primed;
  logic [255:0] exp_vec[$];
  int           exp_cnt[$];
  logic [255:0] obs_vec[$];
  int           obs_cnt[$];

  vec_sample_packer dut (
    .clk(clk), .rst(rst), .flush(flush), .slide_mode(slide_mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec), .out_count(out_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!rst && out_valid && out_ready) begin
      obs_vec.push_back(out_vec);
      obs_cnt.push_back(int'(out_count));
    end

  // Window model: newest sample at the front maps to lane 0.
  function automatic void m_accept(logic [15:0] d, bit last);
    logic [255:0] v;
    if (m_win.size() == 0) m_slide = SLIDE_EN && slide_mode;
    m_win.push_front(d);
    if (m_win.size() > 16) void'(m_win.pop_back());
    if (m_win.size() == 16 || last || m_primed) begin
      v = '0;
      foreach (m_win[i]) v[16*i +: 16] = m_win[i];
      exp_vec.push_back(v);
      exp_cnt.push_back(m_win.size());
      if (m_slide && !last) m_primed = 1'b1;
      else begin m_win.delete(); m_primed = 1'b0; end
    end
  endfunction

  function automatic void m_flush();
    m_win.delete();
    m_primed = 1'b0;
  endfunction

  task automatic send(input logic [15:0] d, input bit last, input bit rnd_rdy);
    bit ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = d; in_last = last;
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
      #1;
      if (in_ready === 1'b1) begin ok = 1'b1; m_accept(d, last); end
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout data %h never accepted", d);
    end
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    m_flush();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_tests++; if (out_vec !== '0) begin n_fail++; $display("FAIL reset_out_vec got %h want 0", out_vec); end
    n_tests++; if (out_count !== 5'd0) begin n_fail++; $display("FAIL reset_out_count got %0d want 0", out_count); end
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_full_vector();
    logic [255:0] ev;
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) send(16'(i), 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) ev[16*i +: 16] = 16'(16 - i);
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL full_latency out_valid got %b want 1", out_valid); end
    n_tests++; if (out_vec !== ev) begin n_fail++; $display("FAIL full_vec got %h want %h", out_vec, ev); end
    n_tests++; if (out_count !== 5'd16) begin n_fail++; $display("FAIL full_count got %0d want 16", out_count); end
    drain();
    n_tests++; if (obs_vec.size() != exp_vec.size()) begin n_fail++; $display("FAIL full_nvec got %0d want %0d", obs_vec.size(), exp_vec.size()); end
    for (int i = 0; i < obs_vec.size() && i < exp_vec.size(); i++) begin
      n_tests++;
      if (obs_vec[i] !== exp_vec[i] || obs_cnt[i] !== exp_cnt[i]) begin n_fail++; $display("FAIL full_out%0d got %h/%0d want %h/%0d", i, obs_vec[i], obs_cnt[i], exp_vec[i], exp_cnt[i]); end
    end
    obs_vec.delete(); obs_cnt.delete(); exp_vec.delete(); exp_cnt.delete();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int i = 0; i < 31; i++) begin
      send(16'h0200 + 16'(i), 1'b0, 1'b0);
      if (i >= 16) begin
        n_tests++;
        if (out_valid !== 1'b1 || out_vec !== exp_vec[0]) begin n_fail++; $display("FAIL bp_hold%0d got %b/%h want 1/%h", i, out_valid, out_vec, exp_vec[0]); end
      end
    end
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'h021F; in_last = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall%0d in_ready got %b want 0", k, in_ready); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release in_ready got %b want 1", in_ready); end
    if (in_ready === 1'b1) m_accept(16'h021F, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_tests++; if (out_vec !== exp_vec[$]) begin n_fail++; $display("FAIL bp_swap got %h want %h", out_vec, exp_vec[$]); end
    drain();
    n_tests++; if (obs_vec.size() != exp_vec.size()) begin n_fail++; $display("FAIL bp_nvec got %0d want %0d", obs_vec.size(), exp_vec.size()); end
    for (int i = 0; i < obs_vec.size() && i < exp_vec.size(); i++) begin
      n_tests++;
      if (obs_vec[i] !== exp_vec[i] || obs_cnt[i] !== exp_cnt[i]) begin n_fail++; $display("FAIL bp_out%0d got %h/%0d want %h/%0d", i, obs_vec[i], obs_cnt[i], exp_vec[i], exp_cnt[i]); end
    end
    obs_vec.delete(); obs_cnt.delete(); exp_vec.delete(); exp_cnt.delete();
  endtask

  task automatic test_partial();
    out_ready = 1'b1;
    send(16'h000A, 1'b0, 1'b0);
    send(16'h000B, 1'b0, 1'b0);
    send(16'h000C, 1'b1, 1'b0);
    n_tests++; if (out_vec !== {208'h0, 16'h000A, 16'h000B, 16'h000C}) begin n_fail++; $display("FAIL partial_vec got %h", out_vec); end
    n_tests++; if (out_count !== 5'd3) begin n_fail++; $display("FAIL partial_count got %0d want 3", out_count); end
    send(16'h0077, 1'b1, 1'b0);
    n_tests++; if (out_vec !== 256'h77 || out_count !== 5'd1) begin n_fail++; $display("FAIL single_last got %h/%0d want 77/1", out_vec, out_count); end
    drain();
    n_tests++; if (obs_vec.size() != exp_vec.size()) begin n_fail++; $display("FAIL partial_nvec got %0d want %0d", obs_vec.size(), exp_vec.size()); end
    for (int i = 0; i < obs_vec.size() && i < exp_vec.size(); i++) begin
      n_tests++;
      if (obs_vec[i] !== exp_vec[i] || obs_cnt[i] !== exp_cnt[i]) begin n_fail++; $display("FAIL partial_out%0d got %h/%0d want %h/%0d", i, obs_vec[i], obs_cnt[i], exp_vec[i], exp_cnt[i]); end
    end
    obs_vec.delete(); obs_cnt.delete(); exp_vec.delete(); exp_cnt.delete();
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send(16'h0050 + 16'(i), 1'b0, 1'b0);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_data = 16'hDEAD;
    #1;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_blocks in_ready got %b want 0", in_ready); end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    m_flush();
    for (int i = 0; i < 16; i++) send(16'h0100 + 16'(i), 1'b0, 1'b0);
    n_tests++; if (out_vec[15:0] !== 16'h010F || out_count !== 5'd16) begin n_fail++; $display("FAIL flush_refill got %h/%0d want 010F/16", out_vec[15:0], out_count); end
    drain();
    n_tests++; if (obs_vec.size() != exp_vec.size()) begin n_fail++; $display("FAIL flush_nvec got %0d want %0d", obs_vec.size(), exp_vec.size()); end
    for (int i = 0; i < obs_vec.size() && i < exp_vec.size(); i++) begin
      n_tests++;
      if (obs_vec[i] !== exp_vec[i] || obs_cnt[i] !== exp_cnt[i]) begin n_fail++; $display("FAIL flush_out%0d got %h/%0d want %h/%0d", i, obs_vec[i], obs_cnt[i], exp_vec[i], exp_cnt[i]); end
    end
    obs_vec.delete(); obs_cnt.delete(); exp_vec.delete(); exp_cnt.delete();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(16'h0300 + 16'(i), 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) send(16'h0400 + 16'(i), 1'b0, 1'b0);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_out_valid got %b want 0", out_valid); end
    n_tests++; if (out_vec !== '0 || out_count !== 5'd0) begin n_fail++; $display("FAIL arst_out_vec got %h/%0d want 0/0", out_vec, out_count); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL arst_in_ready got %b want 0", in_ready); end
    m_flush();
    obs_vec.delete(); obs_cnt.delete(); exp_vec.delete(); exp_cnt.delete();
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) send(16'($urandom), 1'b0, 1'b0);
    drain();
    n_tests++; if (obs_vec.size() != exp_vec.size()) begin n_fail++; $display("FAIL arst_nvec got %0d want %0d", obs_vec.size(), exp_vec.size()); end
    for (int i = 0; i < obs_vec.size() && i < exp_vec.size(); i++) begin
      n_tests++;
      if (obs_vec[i] !== exp_vec[i] || obs_cnt[i] !== exp_cnt[i]) begin n_fail++; $display("FAIL arst_out%0d got %h/%0d want %h/%0d", i, obs_vec[i], obs_cnt[i], exp_vec[i], exp_cnt[i]); end
    end
    obs_vec.delete(); obs_cnt.delete(); exp_vec.delete(); exp_cnt.delete();
  endtask

  task automatic test_slide();
    logic [255:0] last_v;
    int want_n, want_l0, want_l15;
    want_n   = SLIDE_EN ? 5 : 1;
    want_l0  = SLIDE_EN ? 20 : 16;
    want_l15 = SLIDE_EN ? 5 : 1;
    slide_mode = 1'b1; out_ready = 1'b1;
    for (int i = 1; i <= 20; i++) send(16'(i), 1'b0, 1'b0);
    drain();
    last_v = (obs_vec.size() > 0) ? obs_vec[$] : '0;
    n_tests++; if (obs_vec.size() != want_n) begin n_fail++; $display("FAIL slide_nvec got %0d want %0d", obs_vec.size(), want_n); end
    n_tests++; if (int'(last_v[15:0]) != want_l0 || int'(last_v[255:240]) != want_l15) begin n_fail++; $display("FAIL slide_last got l0=%0d l15=%0d want %0d/%0d", last_v[15:0], last_v[255:240], want_l0, want_l15); end
    for (int i = 0; i < obs_vec.size() && i < exp_vec.size(); i++) begin
      n_tests++;
      if (obs_vec[i] !== exp_vec[i] || obs_cnt[i] !== exp_cnt[i]) begin n_fail++; $display("FAIL slide_out%0d got %h/%0d want %h/%0d", i, obs_vec[i], obs_cnt[i], exp_vec[i], exp_cnt[i]); end
    end
    obs_vec.delete(); obs_cnt.delete(); exp_vec.delete(); exp_cnt.delete();
    pulse_flush();
    slide_mode = 1'b0;
  endtask

  task automatic test_random();
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 24) == 0) pulse_flush();
      else begin
        slide_mode = 1'($urandom_range(0, 1));
        send(16'($urandom), $urandom_range(0, 11) == 0, 1'b1);
      end
    end
    drain();
    n_tests++; if (obs_vec.size() != exp_vec.size()) begin n_fail++; $display("FAIL rand_nvec got %0d want %0d", obs_vec.size(), exp_vec.size()); end
    for (int i = 0; i < obs_vec.size() && i < exp_vec.size(); i++) begin
      n_tests++;
      if (obs_vec[i] !== exp_vec[i] || obs_cnt[i] !== exp_cnt[i]) begin n_fail++; $display("FAIL rand_out%0d got %h/%0d want %h/%0d", i, obs_vec[i], obs_cnt[i], exp_vec[i], exp_cnt[i]); end
    end
    obs_vec.delete(); obs_cnt.delete(); exp_vec.delete(); exp_cnt.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0; slide_mode = 1'b0; in_valid = 1'b0;
    in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    m_slide = 1'b0; m_primed = 1'b0;
    test_reset();
    test_full_vector();
    test_backpressure();
    test_partial();
    test_flush();
    test_async_reset();
    test_slide();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
